// File: rtl/input_process_uart.sv
// Receive-side framing stage for the UART link.
// Collects SYNC/LEN/FLAG/data/CHK frames from the uart core RX stream,
// validates length and XOR checksum, and holds one message of 16-bit
// words for a show-ahead consumer.
module input_process_uart #(
  parameter int         DEPTH        = 64,
  parameter int         AW           = 6,
  parameter int         TIMEOUT_CLKS = 100000,
  parameter logic [7:0] SYNC_BYTE    = 8'hAA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  input  logic        FIFO_RD,
  output logic [15:0] FIFO_Q,
  output logic        GOT_FULL_MESSAGE,
  output logic [7:0]  MSG_LEN,
  output logic        PARITY_OUT,
  output logic        BUSY,
  output logic        FRAME_ERR,
  output logic        OVERRUN
);

  localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    DEPTH_W = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_FLAG,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_HOLD
  } state_t;

  state_t state_reg, state_next;

  logic          rx_ready_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [7:0]    len_reg;
  logic [7:0]    xor_reg;
  logic [7:0]    hi_reg;
  logic [7:0]    msg_len_reg;
  logic          flag_reg;
  logic          parity_reg;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [15:0]   q_reg;
  logic [15:0]   mem [DEPTH];

  logic accept;
  logic busy;
  logic len_bad;
  logic last_word;
  logic last_read;
  logic timeout_hit;
  logic mem_we;
  logic frame_drop;
  logic hold_enter;
  logic pop;
  logic pop_last;

  assign accept      = RX_VALID & rx_ready_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_HOLD);
  assign len_bad     = (RX_DATA == 8'd0) || ({1'b0, RX_DATA} > DEPTH_W);
  assign last_word   = ((9'(wptr_reg) + 9'd1) == {1'b0, len_reg});
  assign last_read   = ((9'(rptr_reg) + 9'd1) == {1'b0, len_reg});
  assign timeout_hit = busy && !accept && (to_cnt_reg == TO_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode, one step per accepted byte; also derives datapath strobes
  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    frame_drop = 1'b0;
    hold_enter = 1'b0;
    pop        = 1'b0;
    pop_last   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept && (RX_DATA == SYNC_BYTE)) state_next = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            frame_drop = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_FLAG;
          end
        end
      end
      S_FLAG: begin
        if (accept) state_next = S_DATA_HI;
      end
      S_DATA_HI: begin
        if (accept) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (accept) begin
          mem_we     = 1'b1;
          state_next = last_word ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (RX_DATA == xor_reg) begin
            hold_enter = 1'b1;
            state_next = S_HOLD;
          end else begin
            frame_drop = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (FIFO_RD) begin
          pop = 1'b1;
          if (last_read) begin
            pop_last   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // An idle gap inside a frame abandons it; a byte arriving on the
    // limit cycle still counts as in time.
    if (timeout_hit) begin
      frame_drop = 1'b1;
      state_next = S_IDLE;
    end
  end

  // Message buffer write port (no reset so it maps onto block RAM)
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wptr_reg] <= {hi_reg, RX_DATA};
  end

  // Datapath: ready, timeout counter, checksum, pointers, outputs and pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_ready_reg  <= 1'b0;
      to_cnt_reg    <= '0;
      len_reg       <= '0;
      xor_reg       <= '0;
      hi_reg        <= '0;
      msg_len_reg   <= '0;
      flag_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      q_reg         <= '0;
    end else begin
      rx_ready_reg  <= 1'b1;
      frame_err_reg <= frame_drop;
      overrun_reg   <= (state_reg == S_HOLD) && accept;

      if (!busy || accept || timeout_hit) to_cnt_reg <= '0;
      else                                to_cnt_reg <= to_cnt_reg + TW'(1);

      if (accept) begin
        case (state_reg)
          S_LEN: begin
            xor_reg <= RX_DATA;
            if (!len_bad) len_reg <= RX_DATA;
          end
          S_FLAG: begin
            xor_reg  <= xor_reg ^ RX_DATA;
            flag_reg <= RX_DATA[0];
          end
          S_DATA_HI: begin
            xor_reg <= xor_reg ^ RX_DATA;
            hi_reg  <= RX_DATA;
          end
          S_DATA_LO: xor_reg <= xor_reg ^ RX_DATA;
          default: ;
        endcase
      end

      if (frame_drop || (state_reg == S_IDLE)) wptr_reg <= '0;
      else if (mem_we)                         wptr_reg <= wptr_reg + AW'(1);

      if (pop_last || (state_reg != S_HOLD)) rptr_reg <= '0;
      else if (pop)                          rptr_reg <= rptr_reg + AW'(1);

      // Registered show-ahead read: head on entry, next word after each pop
      if (hold_enter) begin
        q_reg       <= mem[0];
        msg_len_reg <= len_reg;
        parity_reg  <= flag_reg;
      end else if (pop && !pop_last) begin
        q_reg <= mem[rptr_reg + AW'(1)];
      end
    end
  end

  assign RX_READY         = rx_ready_reg;
  assign FIFO_Q           = q_reg;
  assign GOT_FULL_MESSAGE = (state_reg == S_HOLD);
  assign MSG_LEN          = msg_len_reg;
  assign PARITY_OUT       = parity_reg;
  assign BUSY             = busy;
  assign FRAME_ERR        = frame_err_reg;
  assign OVERRUN          = overrun_reg;

endmodule

// File: doc/input_process_uart.md
Name: input_process_uart

Overview:
- Receive-side framing stage for the UART link, downstream of the uart core's AXI-stream RX output.
- Collects bytes into framed messages, validates length and checksum, and buffers one message of 16-bit words.
- Presents the buffered message with GOT_FULL_MESSAGE, FIFO_Q, MSG_LEN and PARITY_OUT, which the output path echoes back as MSG_LEN_IN and PARITY_IN.

Parameters:
DEPTH, 64, maximum words per message; buffer size.
AW, 6, buffer address width; 2^AW >= DEPTH.
TIMEOUT_CLKS, 100000, maximum idle clocks between bytes inside a frame.
SYNC_BYTE, 8'hAA, frame start marker.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  asynchronous active-low reset.
RX_DATA  in  8  byte from the uart core (output_axis_tdata).
RX_VALID  in  1  byte strobe (output_axis_tvalid).
RX_READY  out  1  to output_axis_tready; 0 in reset, registered 1 afterwards; bytes are never back-pressured.
FIFO_RD  in  1  consumer pops one word; ignored unless GOT_FULL_MESSAGE=1.
FIFO_Q  out  16  current head word, show-ahead.
GOT_FULL_MESSAGE  out  1  a validated message is held and not fully read.
MSG_LEN  out  8  word count of the last valid message.
PARITY_OUT  out  1  FLAG bit0 of the last valid message.
BUSY  out  1  mid-frame (any state from LEN through CHK).
FRAME_ERR  out  1  one-cycle pulse when a frame is discarded.
OVERRUN  out  1  one-cycle pulse for each byte dropped while in HOLD.

Behaviour:
- Frame format: SYNC_BYTE, LEN, FLAG, 2*LEN data bytes (MSB first per word), CHK.
- CHK is the XOR of LEN, FLAG and all data bytes.
- Reset: state IDLE, pointers 0, timeout counter 0; all outputs 0 (RX_READY 0, FIFO_Q 0).
- A byte is accepted on a cycle where RX_VALID=1 and RX_READY=1.
- State transitions, one per accepted byte:
  - IDLE: SYNC_BYTE -> LEN. Any other byte is dropped silently.
  - LEN: 1..DEPTH -> latch length, clear running XOR, -> FLAG. Value 0 or >DEPTH -> FRAME_ERR, -> IDLE.
  - FLAG: latch bit0, XOR -> DATA_HI.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO: write {hi,lo} to buffer[wptr], wptr++. If this was the LEN-th word -> CHK, else -> DATA_HI.
  - CHK: byte == running XOR -> HOLD. On the next cycle GOT_FULL_MESSAGE=1, MSG_LEN={len}, PARITY_OUT=flag bit0, FIFO_Q=buffer[0]. Mismatch -> FRAME_ERR, wptr=0, -> IDLE; MSG_LEN and PARITY_OUT keep their previous values.
  - HOLD: each FIFO_RD pops the head; rptr++ and FIFO_Q shows the new head on the following cycle. A FIFO_RD with rptr==len-1 drops GOT_FULL_MESSAGE the next cycle, resets both pointers and returns to IDLE. FIFO_Q holds its last value.
- Bytes accepted in HOLD, including the cycle of the final pop, are dropped with a one-cycle OVERRUN pulse each.
- Timeout applies in LEN..CHK:
  - The counter clears on every accepted byte and increments otherwise.
  - At TIMEOUT_CLKS: FRAME_ERR, wptr=0, -> IDLE.
  - The counter is held at 0 in IDLE and HOLD.
- SYNC_BYTE seen mid-frame is treated as ordinary data; there is no resync.
- FIFO_RD with GOT_FULL_MESSAGE=0 has no effect.
- Reset asserted mid-frame or mid-read: everything returns to reset values immediately; the partial message is lost.
- Latency: GOT_FULL_MESSAGE rises one cycle after the CHK byte is accepted.

Test Plan:
- Valid frame: bytes AA 02 01 12 34 56 78 0B -> GOT_FULL_MESSAGE=1 one cycle after 0B, MSG_LEN=2, PARITY_OUT=1, FIFO_Q=0x1234. After one FIFO_RD, FIFO_Q=0x5678. After a second FIFO_RD, GOT_FULL_MESSAGE=0 and BUSY=0.
- Bad checksum: same frame with last byte 0C -> FRAME_ERR pulses once, GOT_FULL_MESSAGE stays 0, MSG_LEN/PARITY_OUT unchanged. A following valid frame is received correctly.
- Length bounds: AA 00 -> FRAME_ERR; AA 41 (65 > DEPTH) -> FRAME_ERR; AA 40 with 128 data bytes and correct CHK -> MSG_LEN=64 and all 64 words read back in order.
- Timeout: AA 01 00 12, then silence for TIMEOUT_CLKS -> FRAME_ERR exactly at the limit, BUSY=0. A fresh frame then decodes.
- Overrun: while holding an unread message, send 3 bytes -> 3 OVERRUN pulses, held data unchanged. Send a byte on the same cycle as the final FIFO_RD -> OVERRUN pulse, state returns to IDLE.
- Reset mid-frame: deassert RST after AA 02 01 12 -> all outputs 0, RX_READY 0 during reset. A full valid frame afterwards decodes.
